// File: rtl/instruction_store_pkg.sv
// instruction_store_pkg: shared state encoding and constants for the instruction store
package instruction_store_pkg;
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } store_state_t;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
endpackage

// File: rtl/instruction_ram.sv
// instruction_ram: DEPTH x DATA_W storage, one synchronous write port and one asynchronous read port
module instruction_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 56,
  parameter int IDX_W  = 6
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clock) if (we) mem[waddr] <= wdata;
  // raddr may exceed DEPTH-1 when DEPTH is not a power of two; never index past the array
  assign rdata = ({1'b0, raddr} < (IDX_W+1)'(DEPTH)) ? mem[raddr] : '0;
endmodule

// File: rtl/instruction_store.sv
// instruction_store: run-time loadable instruction memory with clear/load/run sequencing
module instruction_store
  import instruction_store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 56
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction_out,
  output logic              fetch_fault,
  output logic              program_ready,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              reload,
  output logic [ADDR_W:0]   word_count
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  store_state_t      state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              we, xfer, run, in_range;
  logic [IDX_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata, rdata;
  assign run           = state_q == RUN;
  assign load_ready    = state_q == LOAD;
  assign program_ready = run;
  assign xfer          = load_valid && load_ready;
  assign word_count    = word_count_q;
  assign in_range      = {1'b0, address} < (ADDR_W+1)'(DEPTH);
  assign fetch_fault   = run && !in_range;
  assign instruction_out = (run && in_range) ? rdata : DATA_W'(NOP_WORD);
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    word_count_d = word_count_q;
    we           = 1'b0;
    waddr        = clr_idx_q;
    wdata        = load_data;
    unique case (state_q)
      CLEAR: begin
        we        = 1'b1;
        wdata     = DATA_W'(NOP_WORD);
        clr_idx_d = clr_idx_q + 1'b1;
        state_d   = (clr_idx_q == IDX_W'(DEPTH-1)) ? LOAD : CLEAR;
      end
      LOAD: begin
        we    = xfer;
        waddr = word_count_q[IDX_W-1:0];
        if (xfer) begin
          word_count_d = word_count_q + 1'b1;
          state_d      = (load_last || word_count_q == (ADDR_W+1)'(DEPTH-1)) ? RUN : LOAD;
        end
      end
      RUN: if (reload) begin
        state_d      = CLEAR;
        clr_idx_d    = '0;
        word_count_d = '0;
      end
      default: state_d = CLEAR;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= CLEAR;
      clr_idx_q    <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      word_count_q <= word_count_d;
    end
  end
  instruction_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (address[IDX_W-1:0]),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_instruction_store.sv
// tb_instruction_store: directed scoreboard bench for instruction_store
module tb_instruction_store;
  localparam int DW = 32, AW = 10, DEPTH = 56;
  logic          clock = 1'b0, reset = 1'b1;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] instruction_out, load_data = '0;
  logic          fetch_fault, program_ready, load_ready;
  logic          load_valid = 1'b0, load_last = 1'b0, reload = 1'b0;
  logic [AW:0]   word_count;
  int            compared = 0, mismatched = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW:0]   exp_q [$];
  instruction_store #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .address(address), .instruction_out(instruction_out),
    .fetch_fault(fetch_fault), .program_ready(program_ready), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .reload(reload), .word_count(word_count)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask
  task automatic fetch(input int a);
    logic [DW:0] e;
    address = AW'(a);
    exp_q.push_back({a >= DEPTH, a < DEPTH ? model[a] : 32'h0});
    #1;
    e = exp_q.pop_front();
    check($sformatf("fetch[%0d]", a), {32'h0, instruction_out}, {32'h0, e[DW-1:0]});
    check($sformatf("fault[%0d]", a), {63'h0, fetch_fault}, {63'h0, e[DW]});
  endtask
  task automatic load_word(input logic [DW-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    model[word_count[5:0]] = d;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    logic pr_seen = 1'b0;
    while (!load_ready && n < 200) begin
      pr_seen |= program_ready;
      tick();
      n++;
    end
    check({tag, "_clear_cycles"}, 64'(n), 64'd56);
    check({tag, "_pr_low"}, {63'h0, pr_seen}, 64'h0);
  endtask
  task automatic do_reload();
    reload = 1'b1;
    #1;
    check("reload_fetch_served", {63'h0, program_ready}, 64'h1);
    tick();
    reload = 1'b0;
    clear_model();
    check("reload_state", {62'h0, program_ready, load_ready}, 64'h0);
    check("reload_wc", 64'(word_count), 64'h0);
  endtask
  initial begin
    clear_model();
    tick();
    check("rst_ready", {62'h0, program_ready, load_ready}, 64'h0);
    check("rst_out", {31'h0, fetch_fault, instruction_out}, 64'h0);
    check("rst_wc", 64'(word_count), 64'h0);
    reset   = 1'b0;
    address = 10'd5;
    wait_ready("boot");
    check("load_out_gated", {31'h0, fetch_fault, instruction_out}, 64'h0);
    address = 10'd900;
    #1;
    check("load_fault_gated", {63'h0, fetch_fault}, 64'h0);
    reload = 1'b1;
    load_word(32'h7C01_0000, 1'b0);
    reload = 1'b0;
    check("reload_ignored_load", {63'h0, load_ready}, 64'h1);
    load_word(32'h3002_0007, 1'b0);
    load_word(32'h0822_1800, 1'b1);
    check("p1_ready", {62'h0, program_ready, load_ready}, 64'h2);
    check("p1_wc", 64'(word_count), 64'd3);
    fetch(1); fetch(0); fetch(2); fetch(10);
    load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
    tick();
    load_valid = 1'b0;
    check("run_load_ignored", 64'(word_count), 64'd3);
    fetch(3);
    do_reload();
    wait_ready("rl1");
    load_word(32'hAAAA_0001, 1'b0);
    load_data = 32'hBAD0_BAD0; load_last = 1'b1;
    tick();
    load_last = 1'b0;
    check("idle_beat_wc", 64'(word_count), 64'd1);
    check("last_no_valid_ignored", {63'h0, load_ready}, 64'h1);
    load_word(32'hAAAA_0002, 1'b0);
    load_word(32'hAAAA_0003, 1'b1);
    check("p2_wc", 64'(word_count), 64'd3);
    fetch(0); fetch(1); fetch(2); fetch(3);
    do_reload();
    wait_ready("rl2");
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("pre_full_ready", {63'h0, load_ready}, 64'h1);
      load_word(32'h1000_0000 + 32'(i), 1'b0);
    end
    check("full_ready", {62'h0, program_ready, load_ready}, 64'h2);
    check("full_wc", 64'(word_count), 64'd56);
    load_valid = 1'b1; load_data = 32'h5757_5757;
    tick();
    load_valid = 1'b0;
    check("full_57th_rejected", 64'(word_count), 64'd56);
    fetch(55); fetch(0); fetch(60); fetch(1023); fetch(55);
    do_reload();
    wait_ready("rl3");
    load_word(32'hFFFF_FFFF, 1'b1);
    check("p4_wc", 64'(word_count), 64'd1);
    fetch(0); fetch(1); fetch(55);
    do_reload();
    wait_ready("rl4");
    load_word(32'h1234_5678, 1'b0);
    load_word(32'h9ABC_DEF0, 1'b0);
    reset = 1'b1;
    load_valid = 1'b1; load_data = 32'h0BAD_0BAD; load_last = 1'b1;
    tick();
    reset = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    clear_model();
    check("midload_rst_ready", {62'h0, program_ready, load_ready}, 64'h0);
    check("midload_rst_wc", 64'(word_count), 64'h0);
    wait_ready("rst2");
    load_word(32'hCAFE_0000, 1'b1);
    check("p5_wc", 64'(word_count), 64'd1);
    fetch(0); fetch(1); fetch(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
